// File: rtl/llc_input_sched_pkg.sv
// Shared definitions for the LLC input scheduler: grant-source indices and
// one-hot codes, plus the scheduler FSM state encoding.
package llc_input_sched_pkg;

  typedef enum logic [1:0] {
    SRC_RST_TB = 2'd0,
    SRC_RSP    = 2'd1,
    SRC_REQ    = 2'd2,
    SRC_DMA    = 2'd3
  } llc_src_e;

  localparam logic [3:0] SRC_OH_RST_TB = 4'b0001;
  localparam logic [3:0] SRC_OH_RSP    = 4'b0010;
  localparam logic [3:0] SRC_OH_REQ    = 4'b0100;
  localparam logic [3:0] SRC_OH_DMA    = 4'b1000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

endpackage

// File: rtl/llc_input_sched_pick.sv
// llc_sched_pick: combinational source selector (fixed priority, req/dma
// round-robin, age override of rsp by the req/dma class).
module llc_sched_pick
  import llc_input_sched_pkg::*;
(
  input  logic [3:0] i_elig,
  input  logic       i_rr_ptr,
  input  logic       i_age_sat,
  output logic [3:0] o_pick
);

  logic       w_cls;
  logic [3:0] w_cls_pick;

  always_comb begin
    w_cls      = i_elig[SRC_REQ] | i_elig[SRC_DMA];
    w_cls_pick = '0;
    if (i_elig[SRC_REQ] && i_elig[SRC_DMA])
      w_cls_pick = i_rr_ptr ? SRC_OH_DMA : SRC_OH_REQ;
    else if (i_elig[SRC_REQ])
      w_cls_pick = SRC_OH_REQ;
    else if (i_elig[SRC_DMA])
      w_cls_pick = SRC_OH_DMA;

    // A saturated age lets the req/dma class jump ahead of rsp only.
    o_pick = '0;
    if (i_elig[SRC_RST_TB])
      o_pick = SRC_OH_RST_TB;
    else if (w_cls && i_age_sat)
      o_pick = w_cls_pick;
    else if (i_elig[SRC_RSP])
      o_pick = SRC_OH_RSP;
    else
      o_pick = w_cls_pick;
  end

endmodule

// File: rtl/llc_input_sched.sv
// LLC input scheduler: grants one of four message sources to the core.
// Optional per-source grant statistics under `LLC_SCHED_STATS_EN.
module llc_input_sched
  import llc_input_sched_pkg::*;
#(
  parameter int unsigned AGE_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rst_tb_valid,
  output logic        rst_tb_ready,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        dma_valid,
  output logic        dma_ready,
  input  logic        req_stall,
  input  logic        flush_busy,
  input  logic        core_idle,
  input  logic        core_done,
  output logic [3:0]  grant_src,
  output logic        grant_valid
`ifdef LLC_SCHED_STATS_EN
  ,
  output logic [63:0] stats_cnt
`endif
);

  logic [1:0]       r_state;
  logic [3:0]       r_grant;
  logic             r_gvalid;
  logic             r_rr;
  logic [AGE_W-1:0] r_age;

  logic [3:0] w_elig;
  logic [3:0] w_pick;
  logic       w_cls_elig;
  logic       w_age_sat;
  logic       w_take;
  logic       w_in_grant;

  always_comb begin
    w_elig[SRC_RST_TB] = rst_tb_valid;
    w_elig[SRC_RSP]    = rsp_valid & ~flush_busy;
    w_elig[SRC_REQ]    = req_valid & ~req_stall & ~flush_busy;
    w_elig[SRC_DMA]    = dma_valid & ~req_stall & ~flush_busy;
    w_cls_elig         = w_elig[SRC_REQ] | w_elig[SRC_DMA];
    w_age_sat          = &r_age;
    w_take             = (r_state == ST_IDLE) & core_idle & (|w_elig);
    w_in_grant         = (r_state == ST_GRANT);
  end

  llc_sched_pick u_pick (
    .i_elig    (w_elig),
    .i_rr_ptr  (r_rr),
    .i_age_sat (w_age_sat),
    .o_pick    (w_pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_gvalid <= 1'b0;
      r_rr     <= 1'b0;
      r_age    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_state  <= ST_GRANT;
            r_grant  <= w_pick;
            r_gvalid <= 1'b1;
            // Pointer records the last class winner: 1 means dma goes next.
            if (w_pick[SRC_REQ] || w_pick[SRC_DMA]) begin
              r_age <= '0;
              r_rr  <= w_pick[SRC_REQ];
            end else if (w_pick[SRC_RSP] && w_cls_elig && !w_age_sat) begin
              r_age <= r_age + 1'b1;
            end
          end
        end
        ST_GRANT: r_state <= ST_BUSY;
        ST_BUSY: begin
          if (core_done) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_gvalid <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_grant  <= '0;
          r_gvalid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rst_tb_ready = w_in_grant & r_grant[SRC_RST_TB];
    rsp_ready    = w_in_grant & r_grant[SRC_RSP];
    req_ready    = w_in_grant & r_grant[SRC_REQ];
    dma_ready    = w_in_grant & r_grant[SRC_DMA];
    grant_src    = r_grant;
    grant_valid  = r_gvalid;
  end

`ifdef LLC_SCHED_STATS_EN
  logic [15:0] r_stats [4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) r_stats[i] <= '0;
    end else if (w_take) begin
      for (int unsigned i = 0; i < 4; i++)
        if (w_pick[i] && (r_stats[i] != '1)) r_stats[i] <= r_stats[i] + 1'b1;
    end
  end

  always_comb stats_cnt = {r_stats[3], r_stats[2], r_stats[1], r_stats[0]};
`endif

endmodule

// File: tb/tb_llc_input_sched.sv
// Scoreboard bench for llc_input_sched (AGE_W=2): directed scenarios push
// expected grants; a negedge monitor pops and compares every ready pulse.
module tb_llc_input_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_stall = 1'b0;
  logic       flush_busy = 1'b0;
  logic       core_idle = 1'b1;
  logic       core_done = 1'b0;
  logic       core_hold = 1'b0;
  logic       rst_tb_ready, rsp_ready, req_ready, dma_ready;
  logic [3:0] grant_src;
  logic       grant_valid;
`ifdef LLC_SCHED_STATS_EN
  logic [63:0] stats_cnt;
`endif

  // Source model: valid while loaded messages exceed consumed ones.
  int unsigned load  [4] = '{0, 0, 0, 0};
  int unsigned taken [4] = '{0, 0, 0, 0};
  logic [3:0]  w_valid;
  logic [3:0]  w_rdy;

  always_comb begin
    for (int i = 0; i < 4; i++) w_valid[i] = (load[i] != taken[i]);
    w_rdy = {dma_ready, req_ready, rsp_ready, rst_tb_ready};
  end

  llc_input_sched #(.AGE_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .rst_tb_valid (w_valid[0]),
    .rst_tb_ready (rst_tb_ready),
    .rsp_valid    (w_valid[1]),
    .rsp_ready    (rsp_ready),
    .req_valid    (w_valid[2]),
    .req_ready    (req_ready),
    .dma_valid    (w_valid[3]),
    .dma_ready    (dma_ready),
    .req_stall    (req_stall),
    .flush_busy   (flush_busy),
    .core_idle    (core_idle),
    .core_done    (core_done),
    .grant_src    (grant_src),
    .grant_valid  (grant_valid)
`ifdef LLC_SCHED_STATS_EN
    ,
    .stats_cnt    (stats_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    for (int i = 0; i < 4; i++)
      if (w_rdy[i] && w_valid[i]) taken[i] = taken[i] + 1;

  // Core model: stays busy two cycles after taking a message, then pulses done.
  int unsigned busy_cnt = 0;
  always @(negedge clk) begin
    core_done = 1'b0;
    if (grant_valid && !(|w_rdy) && rst) begin
      busy_cnt = busy_cnt + 1;
      if (busy_cnt >= 2 && !core_hold) begin
        core_done = 1'b1;
        busy_cnt  = 0;
      end
    end else begin
      busy_cnt = 0;
    end
  end

  typedef struct {
    int          id;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic [3:0] exp_q [$];
  chk_t       chk_q [$];
  int         vectors = 0;
  int         errors  = 0;

  function automatic string chk_name(input int id);
    case (id)
      0: return "reset_grant_src";
      1: return "reset_grant_valid";
      2: return "reset_ready";
      3: return "wait_timeout";
      4: return "midbusy_grant_src";
      5: return "midbusy_grant_valid";
      6: return "post_reset_rsp_ready";
      7: return "age_after_req";
      8: return "stats_cnt";
      9: return "flush_no_grant";
      10: return "stall_no_grant";
      default: return "unknown";
    endcase
  endfunction

  task automatic post(input int id, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.id = id; c.act = act; c.exp = exp;
    chk_q.push_back(c);
  endtask

  // Monitor: owns both counters; compares ready pulses and posted checks.
  always @(negedge clk) begin
    logic [3:0] e;
    chk_t c;
    if (|w_rdy) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: ready=%b grant_src=%b, required no grant", w_rdy, grant_src);
      end else begin
        e = exp_q.pop_front();
        if (w_rdy !== e || grant_src !== e) begin
          errors++;
          $display("FAIL grant: ready=%b grant_src=%b, required %b", w_rdy, grant_src, e);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      vectors++;
      if (c.act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %0h, required %0h", chk_name(c.id), c.act, c.exp);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) load[i] = taken[i];
    req_stall = 1'b0; flush_busy = 1'b0; core_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic add(input int src, input int unsigned n);
    load[src] = load[src] + n;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || grant_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) post(3, 64'd0, 64'd1);
  endtask

  task automatic wait_rdy(input int src);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!w_rdy[src] && n < 100);
    if (!w_rdy[src]) post(3, 64'd0, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    post(0, {60'd0, grant_src}, 64'd0);
    post(1, {63'd0, grant_valid}, 64'd0);
    post(2, {60'd0, w_rdy}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // All four eligible: rst_tb, then rsp, req, dma
    do_reset();
    add(0, 1); add(1, 1); add(2, 1); add(3, 1);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    drain();

    // req/dma round robin
    do_reset();
    add(2, 4); add(3, 4);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    end
    drain();

    // Age override with AGE_W=2: three rsp then one req, twice
    do_reset();
    add(1, 7); add(2, 2);
    for (int k = 0; k < 2; k++) begin
      repeat (3) exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
    end
    exp_q.push_back(4'b0010);
    drain();
    post(7, {62'd0, dut.r_age}, 64'd0);

    // req_stall blocks req; release lets it through
    do_reset();
    req_stall = 1'b1;
    add(1, 1); add(2, 1);
    exp_q.push_back(4'b0010);
    drain();
    repeat (8) @(negedge clk);
    post(10, {63'd0, grant_valid}, 64'd0);
    exp_q.push_back(4'b0100);
    req_stall = 1'b0;
    drain();

    // flush_busy: only rst_tb passes; rsp and req follow once flush ends
    do_reset();
    flush_busy = 1'b1;
    add(0, 1); add(1, 1); add(2, 1);
    exp_q.push_back(4'b0001);
    drain();
    repeat (8) @(negedge clk);
    post(9, {63'd0, grant_valid}, 64'd0);
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    flush_busy = 1'b0;
    drain();

    // Stall change during BUSY does not disturb the current grant
    do_reset();
    add(3, 1);
    core_hold = 1'b1;
    exp_q.push_back(4'b1000);
    wait_rdy(3);
    req_stall = 1'b1;
    flush_busy = 1'b1;
    repeat (3) @(negedge clk);
    post(4, {60'd0, grant_src}, 64'h8);
    req_stall = 1'b0; flush_busy = 1'b0; core_hold = 1'b0;
    drain();

    // Reset mid-BUSY, then pending rsp granted right after release
    do_reset();
    add(1, 2);
    exp_q.push_back(4'b0010);
    wait_rdy(1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    post(4, {60'd0, grant_src}, 64'd0);
    post(5, {63'd0, grant_valid}, 64'd0);
    exp_q.push_back(4'b0010);
    rst = 1'b1;
    @(negedge clk);
    post(6, {63'd0, rsp_ready}, 64'd1);
    drain();

`ifdef LLC_SCHED_STATS_EN
    do_reset();
    add(3, 5);
    repeat (5) exp_q.push_back(4'b1000);
    drain();
    post(8, stats_cnt, {16'd5, 48'd0});
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
